// File: rtl/sprite_frame_sequencer.sv
// Sequences background, per-sprite load/draw, frame-divided wait, erase and
// position update for NUM_SPRITES sprites sharing one pixel datapath.
module sprite_frame_sequencer #(
  parameter int unsigned NUM_SPRITES = 2,
  parameter int unsigned SEL_W       = 1,
  parameter int unsigned FRAME_DIV   = 15,
  parameter int unsigned STEP_W      = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              frame_tick,
  input  logic              pause,
  input  logic              redraw_req,
  input  logic              bg_done,
  input  logic              draw_done,
  output logic              draw_bg,
  output logic              ld_sprite,
  output logic              draw_sprite,
  output logic              erase_sprite,
  output logic [SEL_W-1:0]  sprite_sel,
  output logic              update,
  output logic              writeEn,
  output logic              step_done,
  output logic [STEP_W-1:0] step_cnt
);

  localparam int unsigned DIV_W = 8;
  localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(NUM_SPRITES - 1);
  localparam logic [DIV_W-1:0] LAST_DIV = DIV_W'(FRAME_DIV - 1);

  typedef enum logic [2:0] {
    S_BG     = 3'd0,
    S_LOAD   = 3'd1,
    S_DRAW   = 3'd2,
    S_WAIT   = 3'd3,
    S_ERASE  = 3'd4,
    S_UPDATE = 3'd5
  } state_t;

  state_t              state, state_nxt;
  logic [SEL_W-1:0]    sel_q, sel_nxt;
  logic [DIV_W-1:0]    div_q, div_nxt;
  logic [STEP_W-1:0]   step_q, step_nxt;
  logic                draw_bg_nxt, ld_sprite_nxt, draw_sprite_nxt, erase_sprite_nxt;
  logic                update_nxt, writeEn_nxt;

  // Next-state, sprite index, divider and step counter
  always_comb begin
    state_nxt = state;
    sel_nxt   = sel_q;
    div_nxt   = div_q;
    step_nxt  = step_q;
    case (state)
      S_BG: begin
        if (bg_done) begin
          state_nxt = S_LOAD;
          sel_nxt   = '0;
        end
      end
      S_LOAD: state_nxt = S_DRAW;
      S_DRAW: begin
        if (draw_done) begin
          if (sel_q != LAST_SEL) begin
            sel_nxt   = sel_q + SEL_W'(1);
            state_nxt = S_LOAD;
          end else begin
            state_nxt = S_WAIT;
            div_nxt   = '0;
          end
        end
      end
      S_WAIT: begin
        // Redraw outranks the terminal tick and drops the partial count
        if (redraw_req) begin
          state_nxt = S_BG;
          div_nxt   = '0;
        end else if (frame_tick && !pause) begin
          if (div_q == LAST_DIV) begin
            state_nxt = S_ERASE;
            sel_nxt   = '0;
            div_nxt   = '0;
          end else begin
            div_nxt = div_q + DIV_W'(1);
          end
        end
      end
      S_ERASE: begin
        if (draw_done) begin
          if (sel_q != LAST_SEL) sel_nxt = sel_q + SEL_W'(1);
          else                   state_nxt = S_UPDATE;
        end
      end
      S_UPDATE: begin
        step_nxt  = step_q + STEP_W'(1);
        sel_nxt   = '0;
        state_nxt = S_LOAD;
      end
      default: begin
        state_nxt = S_BG;
        sel_nxt   = '0;
        div_nxt   = '0;
      end
    endcase
  end

  // Moore decode of the upcoming state, so the registered outputs track state
  always_comb begin
    draw_bg_nxt      = (state_nxt == S_BG);
    ld_sprite_nxt    = (state_nxt == S_LOAD);
    draw_sprite_nxt  = (state_nxt == S_DRAW);
    erase_sprite_nxt = (state_nxt == S_ERASE);
    update_nxt       = (state_nxt == S_UPDATE);
    writeEn_nxt      = draw_bg_nxt || draw_sprite_nxt || erase_sprite_nxt;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state        <= S_BG;
      sel_q        <= '0;
      div_q        <= '0;
      step_q       <= '0;
      draw_bg      <= 1'b1;
      ld_sprite    <= 1'b0;
      draw_sprite  <= 1'b0;
      erase_sprite <= 1'b0;
      update       <= 1'b0;
      step_done    <= 1'b0;
      writeEn      <= 1'b1;
    end else begin
      state        <= state_nxt;
      sel_q        <= sel_nxt;
      div_q        <= div_nxt;
      step_q       <= step_nxt;
      draw_bg      <= draw_bg_nxt;
      ld_sprite    <= ld_sprite_nxt;
      draw_sprite  <= draw_sprite_nxt;
      erase_sprite <= erase_sprite_nxt;
      update       <= update_nxt;
      step_done    <= update_nxt;
      writeEn      <= writeEn_nxt;
    end
  end

  assign sprite_sel = sel_q;
  assign step_cnt   = step_q;

endmodule

// File: tb/tb_sprite_frame_sequencer.sv
// Scoreboard bench: stimulus queues expected output snapshots, a monitor pops
// one per observed output change; probes pin the state at chosen instants.
module tb_sprite_frame_sequencer;

  localparam int unsigned NUM_SPRITES = 2;
  localparam int unsigned SEL_W       = 1;
  localparam int unsigned FRAME_DIV   = 3;
  localparam int unsigned STEP_W      = 8;

  localparam int K_BG = 0, K_LOAD = 1, K_DRAW = 2, K_WAIT = 3, K_ERASE = 4, K_UPD = 5;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              frame_tick = 1'b0, pause = 1'b0, redraw_req = 1'b0;
  logic              bg_done = 1'b0, draw_done = 1'b0;
  logic              draw_bg, ld_sprite, draw_sprite, erase_sprite, update, writeEn, step_done;
  logic [SEL_W-1:0]  sprite_sel;
  logic [STEP_W-1:0] step_cnt;

  sprite_frame_sequencer #(
    .NUM_SPRITES(NUM_SPRITES), .SEL_W(SEL_W), .FRAME_DIV(FRAME_DIV), .STEP_W(STEP_W)
  ) dut (
    .clk(clk), .reset_n(reset_n), .frame_tick(frame_tick), .pause(pause),
    .redraw_req(redraw_req), .bg_done(bg_done), .draw_done(draw_done),
    .draw_bg(draw_bg), .ld_sprite(ld_sprite), .draw_sprite(draw_sprite),
    .erase_sprite(erase_sprite), .sprite_sel(sprite_sel), .update(update),
    .writeEn(writeEn), .step_done(step_done), .step_cnt(step_cnt)
  );

  always #5 clk = ~clk;

  int compared = 0;
  int mismatched = 0;
  logic [15:0] exp_q[$];
  logic [15:0] probe_q[$];
  logic [15:0] prev_snap = 'x;

  // {bg, ld, draw, erase, update, we, step_done, sel, step_cnt}
  function automatic logic [15:0] mk(input int k, input int sel, input int step);
    logic [6:0] f;
    case (k)
      K_BG:    f = 7'b1000010;
      K_LOAD:  f = 7'b0100000;
      K_DRAW:  f = 7'b0010010;
      K_ERASE: f = 7'b0001010;
      K_UPD:   f = 7'b0000101;
      default: f = 7'b0000000;
    endcase
    return {f, 1'(sel), 8'(step)};
  endfunction

  function automatic logic [15:0] dut_snap();
    return {draw_bg, ld_sprite, draw_sprite, erase_sprite, update, writeEn,
            step_done, sprite_sel, step_cnt};
  endfunction

  // Monitor: sampled 1 time unit after the falling edge
  always @(negedge clk) begin
    logic [15:0] cur, e;
    #1;
    cur = dut_snap();
    if (cur !== prev_snap) begin
      compared++;
      if (exp_q.size() == 0) begin
        mismatched++;
        $display("FAIL change_unexpected: got %h, required no change", cur);
      end else begin
        e = exp_q.pop_front();
        if (cur !== e) begin
          mismatched++;
          $display("FAIL change_event @%0t: got %h, required %h", $time, cur, e);
        end
      end
      prev_snap = cur;
    end
    if (probe_q.size() != 0) begin
      e = probe_q.pop_front();
      compared++;
      if (cur !== e) begin
        mismatched++;
        $display("FAIL probe @%0t: got %h, required %h", $time, cur, e);
      end
    end
    if (writeEn === 1'b1) begin
      compared++;
      if ((int'(draw_bg) + int'(draw_sprite) + int'(erase_sprite)) != 1) begin
        mismatched++;
        $display("FAIL one_enable @%0t: got bg=%b draw=%b erase=%b, required exactly one",
                 $time, draw_bg, draw_sprite, erase_sprite);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic pulse_bg();
    bg_done = 1'b1; @(negedge clk); bg_done = 1'b0;
  endtask
  task automatic pulse_dd();
    draw_done = 1'b1; @(negedge clk); draw_done = 1'b0;
  endtask
  task automatic pulse_tick();
    frame_tick = 1'b1; @(negedge clk); frame_tick = 1'b0;
  endtask

  task automatic push_draw_all(input int step);
    exp_q.push_back(mk(K_LOAD, 0, step));
    exp_q.push_back(mk(K_DRAW, 0, step));
    exp_q.push_back(mk(K_LOAD, 1, step));
    exp_q.push_back(mk(K_DRAW, 1, step));
    exp_q.push_back(mk(K_WAIT, 1, step));
  endtask

  // Entered at a falling edge while in S_LOAD with sel 0; leaves in S_WAIT
  task automatic draw_all();
    idle(1);
    idle(2);
    pulse_dd();
    idle(1);
    pulse_dd();
  endtask

  task automatic three_ticks(input int step);
    pulse_tick(); idle(1);
    pulse_tick(); idle(1);
    probe_q.push_back(mk(K_WAIT, 1, step));
    pulse_tick();
  endtask

  // One animation step starting in S_WAIT; mode 1 pauses ticks 2-4 of 6
  task automatic run_step(input int s, input int mode);
    exp_q.push_back(mk(K_ERASE, 0, s));
    exp_q.push_back(mk(K_ERASE, 1, s));
    exp_q.push_back(mk(K_UPD, 1, s));
    push_draw_all(s + 1);
    if (mode == 0) begin
      three_ticks(s);
    end else begin
      for (int i = 1; i <= 6; i++) begin
        pause = (i >= 2 && i <= 4);
        if (i == 6) probe_q.push_back(mk(K_WAIT, 1, s));
        pulse_tick();
        pause = 1'b0;
        if (i != 6) idle(1);
      end
    end
    idle(1); pulse_dd();
    idle(1); pulse_dd();
    idle(1);
    draw_all();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no completion, required finish within time budget");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset, background, then first load/draw of both sprites
    exp_q.push_back(mk(K_BG, 0, 0));
    push_draw_all(0);
    idle(3);
    reset_n = 1'b1;
    idle(2);
    probe_q.push_back(mk(K_BG, 0, 0));
    pulse_bg();
    draw_all();

    run_step(0, 0);
    run_step(1, 1);

    // Redraw coinciding with the terminal tick
    exp_q.push_back(mk(K_BG, 1, 2));
    push_draw_all(2);
    pulse_tick(); idle(1);
    pulse_tick(); idle(1);
    redraw_req = 1'b1; frame_tick = 1'b1;
    @(negedge clk);
    redraw_req = 1'b0; frame_tick = 1'b0;
    idle(2);
    pulse_bg();
    draw_all();

    run_step(2, 0);

    // Reset while erasing sprite 1
    exp_q.push_back(mk(K_ERASE, 0, 3));
    exp_q.push_back(mk(K_ERASE, 1, 3));
    exp_q.push_back(mk(K_BG, 0, 0));
    push_draw_all(0);
    three_ticks(3);
    idle(1); pulse_dd();
    idle(1);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    idle(2);
    pulse_bg();
    draw_all();

    // 256 steps: step_cnt wraps 255 -> 0
    for (int i = 0; i < 256; i++) run_step(i % 256, 0);

    idle(5);
    compared++;
    if (exp_q.size() != 0 || probe_q.size() != 0) begin
      mismatched++;
      $display("FAIL drain: got %0d events and %0d probes outstanding, required 0",
               exp_q.size(), probe_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/sprite_frame_sequencer.md
Name: sprite_frame_sequencer

Overview:
Parametrised Moore FSM that sequences VGA frame rendering for NUM_SPRITES independent sprites over one shared pixel datapath.
- Sequence: background draw once, then per animation step: load+draw every sprite, wait FRAME_DIV vsync ticks, erase every sprite, then one position-update pulse.
- Adds over the single-sprite controller: multi-sprite iteration, a programmable frame divider, pause, and on-demand background redraw.
- Sits between the game-logic position registers and the pixel writer / VGA adapter.

Parameters:
NUM_SPRITES, 2, number of sprites sequenced per step (1..16)
SEL_W, 1, width of sprite_sel; must satisfy 2^SEL_W >= NUM_SPRITES
FRAME_DIV, 15, frame_tick pulses per animation step (1..255)
STEP_W, 8, width of step_cnt

Ports:
clk  in  1  system clock
reset_n  in  1  synchronous active-low reset
frame_tick  in  1  one-cycle pulse per VGA frame
pause  in  1  level; freezes the divider count in S_WAIT
redraw_req  in  1  level; request background redraw, honoured only in S_WAIT
bg_done  in  1  pulse from background painter: last pixel written
draw_done  in  1  pulse from sprite painter: current draw/erase op finished
draw_bg  out  1  background painter enable
ld_sprite  out  1  load position/style registers of sprite sprite_sel
draw_sprite  out  1  sprite painter enable, draw mode
erase_sprite  out  1  sprite painter enable, erase mode
sprite_sel  out  SEL_W  index of the sprite being loaded/drawn/erased
update  out  1  one-cycle pulse: game logic advances all sprite positions
writeEn  out  1  VGA write enable
step_done  out  1  one-cycle pulse, coincident with update
step_cnt  out  STEP_W  completed animation steps, wraps modulo 2^STEP_W

Behaviour:
- Reset: reset_n sampled low at a clk edge forces:
  - state = S_BG
  - sprite_sel = 0, divider count = 0, step_cnt = 0
- Outputs after reset: draw_bg = 1, writeEn = 1, all other outputs 0.
- Reset mid-operation aborts any op. No pulse is generated on reset.
- Outputs are decoded combinationally from registered state (Moore).
  - Only inputs change next state.
  - Inputs are sampled only in the states listed below; ignored elsewhere.
- States and transitions:
  - S_BG: draw_bg = 1, writeEn = 1. bg_done -> S_LOAD with sprite_sel = 0.
  - S_LOAD: ld_sprite = 1, exactly one cycle -> S_DRAW.
  - S_DRAW: draw_sprite = 1, writeEn = 1. On draw_done:
    - sprite_sel < NUM_SPRITES-1: sprite_sel++ -> S_LOAD
    - otherwise: -> S_WAIT, divider count cleared to 0
  - S_WAIT: all enables 0. Priority order:
    - redraw_req -> S_BG
    - frame_tick && !pause && count == FRAME_DIV-1 -> S_ERASE, sprite_sel = 0
    - frame_tick && !pause -> count++
  - S_ERASE: erase_sprite = 1, writeEn = 1. On draw_done:
    - sprite_sel < NUM_SPRITES-1: sprite_sel++ and stay in S_ERASE
    - otherwise: -> S_UPDATE
  - S_UPDATE: update = 1, step_done = 1, one cycle.
    - step_cnt++ (wraps)
    - sprite_sel = 0 -> S_LOAD
- Illegal state encodings -> S_BG next cycle.
- sprite_sel never exceeds NUM_SPRITES-1.
- NUM_SPRITES = 1:
  - S_DRAW goes straight to S_WAIT.
  - S_ERASE goes to S_UPDATE on the first draw_done.
- FRAME_DIV = 1: the first unpaused frame_tick in S_WAIT exits.
- Pause held through a frame_tick: that tick is not counted.
- redraw_req and the terminal tick in the same cycle: redraw wins, and the divider count is discarded.
- Exactly one of draw_bg / draw_sprite / erase_sprite is high whenever writeEn = 1.

Test Plan:
- Reset, NUM_SPRITES=2, FRAME_DIV=3 -> draw_bg=writeEn=1 until bg_done; then LOAD0, DRAW0 (draw_done), LOAD1, DRAW1 (draw_done); then S_WAIT with all outputs 0.
- In S_WAIT, issue 3 frame_ticks -> erase_sprite with sel 0 then 1 (each on draw_done); then a single update/step_done pulse; step_cnt=1; then ld_sprite with sel=0.
- Pause asserted over ticks 2-4 of 6 -> exit S_WAIT only after the 3rd unpaused tick.
- redraw_req coincident with the terminal tick -> S_BG, no erase, step_cnt unchanged.
- Assert reset_n=0 mid S_ERASE with sel=1 -> next cycle: draw_bg=1, sprite_sel=0, step_cnt=0.
- Run 256 steps with STEP_W=8 -> step_cnt wraps 255->0. Over the whole run, writeEn is never high without exactly one enable high.
